msx_bus_sync: RTL and testbench

MSX_BUS_SYNC -- requirements
Module: msx_bus_sync

---
 rtl/msx_bus_pkg.sv | 19 +
 rtl/msx_sync.sv | 22 ++
 rtl/msx_bus_sync.sv | 147 ++++++++++++++
 tb/tb_msx_bus_sync.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/msx_bus_pkg.sv
// Shared definitions for the MSX cartridge bus synchroniser.
package msx_bus_pkg;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned SETTLE_CYCLES_DEF = 3;

  // Wide enough for SETTLE_CYCLES up to 15 and the post-reset fill count.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_STROBE,
    ST_CLAIM,
    ST_HOLD,
    ST_RELEASE
  } bus_state_t;

endpackage

// File: rtl/msx_sync.sv
// Multi-flop synchroniser for one asynchronous, active-low bus strobe.
// Flops reset to 1 so a reset never looks like an asserted strobe.
module msx_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Shift the raw pin through DEPTH flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stages <= '1;
    else          stages <= {stages[DEPTH-2:0], d};
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/msx_bus_sync.sv
// MSX cartridge bus front end: synchronises the asynchronous strobes,
// waits for the bus to settle, latches address/data/strobes, issues a
// single-cycle enable and optionally drives read data back to the bus.
module msx_bus_sync
  import msx_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        bus_rd_n,
  input  logic        bus_wr_n,
  input  logic        bus_merq_n,
  input  logic        bus_iorq_n,
  input  logic        bus_sltsl_n,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  output logic [15:0] addr,
  output logic [7:0]  cdin,
  output logic        rd_n,
  output logic        wr_n,
  output logic        sltsl_n,
  output logic        iorq_n,
  output logic        enable,
  input  logic        busreq,
  input  logic [7:0]  cdout
);

  logic rd_s, wr_s, merq_s, iorq_s, sltsl_s;

  msx_sync #(.DEPTH(SYNC_STAGES)) u_sync_rd    (.clk(clk), .reset_n(reset_n), .d(bus_rd_n),    .q(rd_s));
  msx_sync #(.DEPTH(SYNC_STAGES)) u_sync_wr    (.clk(clk), .reset_n(reset_n), .d(bus_wr_n),    .q(wr_s));
  msx_sync #(.DEPTH(SYNC_STAGES)) u_sync_merq  (.clk(clk), .reset_n(reset_n), .d(bus_merq_n),  .q(merq_s));
  msx_sync #(.DEPTH(SYNC_STAGES)) u_sync_iorq  (.clk(clk), .reset_n(reset_n), .d(bus_iorq_n),  .q(iorq_s));
  msx_sync #(.DEPTH(SYNC_STAGES)) u_sync_sltsl (.clk(clk), .reset_n(reset_n), .d(bus_sltsl_n), .q(sltsl_s));

  bus_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             oe_q;
  logic             strobes_idle;
  logic             cycle_req;
  logic             settle_done;

  assign strobes_idle = rd_s && wr_s;
  assign cycle_req    = (!rd_s || !wr_s) && (!merq_s || !iorq_s);
  assign settle_done  = (cnt == CNT_W'(SETTLE_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; IDLE only accepts a cycle once armed after reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (armed && cycle_req) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (strobes_idle)       state_nxt = ST_IDLE;
                  else if (settle_done)   state_nxt = ST_STROBE;
      ST_STROBE:  state_nxt = ST_CLAIM;
      ST_CLAIM:   state_nxt = ST_HOLD;
      ST_HOLD:    if (strobes_idle)       state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so bus_oe cannot be high outside HOLD.
  always_comb begin
    enable = (state == ST_STROBE);
    bus_oe = (state == ST_HOLD) && oe_q;
  end

  // Counter, arming, latches and read-data capture.
  // After reset the counter first waits for the synchronisers to fill with
  // real pin values, then arming needs rd/wr seen high, so a cycle already
  // in progress at reset release is ignored. Latched strobes are released
  // on the HOLD->RELEASE edge so they drop together with bus_oe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      armed    <= 1'b0;
      oe_q     <= 1'b0;
      bus_dout <= '0;
      addr     <= '0;
      cdin     <= '0;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      sltsl_n  <= 1'b1;
      iorq_n   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!armed) begin
            if (cnt < CNT_W'(SYNC_STAGES)) begin
              cnt <= cnt + 1'b1;
            end else if (strobes_idle) begin
              armed <= 1'b1;
              cnt   <= '0;
            end
          end else begin
            cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (strobes_idle) begin
            cnt <= '0;
          end else if (settle_done) begin
            cnt     <= '0;
            addr    <= bus_addr;
            cdin    <= bus_din;
            rd_n    <= rd_s;
            wr_n    <= wr_s;
            sltsl_n <= sltsl_s;
            iorq_n  <= iorq_s;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLAIM: begin
          if (busreq && !rd_n && wr_n) begin
            bus_dout <= cdout;
            oe_q     <= 1'b1;
          end else begin
            oe_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (strobes_idle) begin
            oe_q    <= 1'b0;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            sltsl_n <= 1'b1;
            iorq_n  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msx_bus_sync.sv
// Randomised bench for msx_bus_sync with a transaction-level reference model.
module tb_msx_bus_sync;

  localparam int unsigned K = 2;
  localparam int unsigned S = 3;

  localparam int KIND_RD    = 0;
  localparam int KIND_WR    = 1;
  localparam int KIND_RW    = 2;
  localparam int KIND_NOSEL = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_rd_n, bus_wr_n, bus_merq_n, bus_iorq_n, bus_sltsl_n;
  logic [7:0]  bus_dout;
  logic        bus_oe;
  logic [15:0] addr;
  logic [7:0]  cdin;
  logic        rd_n, wr_n, sltsl_n, iorq_n;
  logic        enable;
  logic        busreq;
  logic [7:0]  cdout;

  always #5 clk = ~clk;

  msx_bus_sync #(
    .SYNC_STAGES  (K),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus_addr   (bus_addr),
    .bus_din    (bus_din),
    .bus_rd_n   (bus_rd_n),
    .bus_wr_n   (bus_wr_n),
    .bus_merq_n (bus_merq_n),
    .bus_iorq_n (bus_iorq_n),
    .bus_sltsl_n(bus_sltsl_n),
    .bus_dout   (bus_dout),
    .bus_oe     (bus_oe),
    .addr       (addr),
    .cdin       (cdin),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .sltsl_n    (sltsl_n),
    .iorq_n     (iorq_n),
    .enable     (enable),
    .busreq     (busreq),
    .cdout      (cdout)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_addr;
  logic [7:0]  exp_cdin;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pins_idle();
    bus_rd_n    = 1'b1;
    bus_wr_n    = 1'b1;
    bus_merq_n  = 1'b1;
    bus_iorq_n  = 1'b1;
    bus_sltsl_n = 1'b1;
  endtask

  // One bus cycle: strobes low for len clock edges, then high for gap edges.
  // Called just after a falling edge. late=1 when the previous cycle left
  // only one idle clock, delaying recognition by one clock.
  task automatic run_cycle(input int kind, input logic [15:0] a, input logic [7:0] d,
                           input int len, input int gap, input logic br,
                           input logic [7:0] cd, input logic slt, input logic io,
                           input int late);
    int          en_cnt, en_at, oe_cnt, oe_last, exp_oe;
    logic [15:0] a_en;
    logic [7:0]  c_en, dout_seen;
    logic [3:0]  str_en;
    bit          exp_en;
    en_cnt = 0; en_at = 0; oe_cnt = 0; oe_last = 0;
    a_en = '0; c_en = '0; dout_seen = '0; str_en = '1;

    bus_addr    = a;
    bus_din     = d;
    bus_rd_n    = !(kind == KIND_RD || kind == KIND_RW || kind == KIND_NOSEL);
    bus_wr_n    = !(kind == KIND_WR || kind == KIND_RW);
    bus_merq_n  = (kind == KIND_NOSEL) ? 1'b1 : io;
    bus_iorq_n  = (kind == KIND_NOSEL) ? 1'b1 : !io;
    bus_sltsl_n = !slt;
    busreq      = br;
    cdout       = cd;

    for (int j = 1; j <= len + gap; j++) begin
      @(posedge clk);
      #1;
      if (j == len) pins_idle();
      @(negedge clk);
      if (enable) begin
        en_cnt++;
        en_at  = j;
        a_en   = addr;
        c_en   = cdin;
        str_en = {rd_n, wr_n, sltsl_n, iorq_n};
      end
      if (bus_oe) begin
        oe_cnt++;
        oe_last   = j;
        dout_seen = bus_dout;
      end
    end

    exp_en = (kind != KIND_NOSEL) && (len >= int'(S) + 1);
    check_val("enable_count", en_cnt, exp_en ? 1 : 0);
    if (exp_en) begin
      exp_addr = a;
      exp_cdin = d;
      check_val("enable_time", en_at, K + S + 1 + late);
      check_val("addr_at_enable", a_en, a);
      check_val("cdin_at_enable", c_en, d);
      check_val("strobes_at_enable", str_en,
                {!(kind == KIND_RD || kind == KIND_RW),
                 !(kind == KIND_WR || kind == KIND_RW), !slt, !io});
    end
    exp_oe = (exp_en && kind == KIND_RD && br) ? (len - int'(S) - 2 - late) : 0;
    check_val("oe_cycles", oe_cnt, exp_oe);
    if (exp_oe > 0) begin
      check_val("oe_release_time", oe_last, len + K);
      check_val("bus_dout", dout_seen, cd);
    end
    if (gap >= int'(K) + 1) begin
      check_val("addr_retained", addr, exp_addr);
      check_val("cdin_retained", cdin, exp_cdin);
      check_val("strobes_released", {rd_n, wr_n, sltsl_n, iorq_n}, 4'hF);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_addr"},     addr, 16'h0000);
    check_val({tag, "_cdin"},     cdin, 8'h00);
    check_val({tag, "_dout"},     bus_dout, 8'h00);
    check_val({tag, "_oe"},       bus_oe, 1'b0);
    check_val({tag, "_enable"},   enable, 1'b0);
    check_val({tag, "_strobes"},  {rd_n, wr_n, sltsl_n, iorq_n}, 4'hF);
  endtask

  initial begin
    int en_cnt;
    reset_n  = 1'b0;
    bus_addr = '0;
    bus_din  = '0;
    busreq   = 1'b0;
    cdout    = '0;
    pins_idle();
    exp_addr = '0;
    exp_cdin = '0;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (K + 6) @(negedge clk);

    // Read FFFFh from selected slot, downstream claims with 5Ah.
    run_cycle(KIND_RD, 16'hFFFF, 8'h00, S + 8, K + 2, 1'b1, 8'h5A, 1'b1, 1'b0, 0);
    // Memory write 4000h <- 3Ch, busreq asserted must be ignored.
    run_cycle(KIND_WR, 16'h4000, 8'h3C, S + 6, K + 2, 1'b1, 8'hEE, 1'b1, 1'b0, 0);
    // Read nobody claims.
    run_cycle(KIND_RD, 16'h1234, 8'h77, S + 5, K + 2, 1'b0, 8'h99, 1'b0, 1'b0, 0);
    // Two-clock rd glitch aborts during settle.
    run_cycle(KIND_RD, 16'hBEEF, 8'h11, 2, K + 3, 1'b1, 8'h22, 1'b1, 1'b0, 0);
    // rd and wr both low: write wins, no drive.
    run_cycle(KIND_RW, 16'h2345, 8'h66, S + 5, K + 2, 1'b1, 8'h33, 1'b0, 1'b0, 0);
    // rd low with neither merq nor iorq: not a bus cycle.
    run_cycle(KIND_NOSEL, 16'h5555, 8'h44, S + 5, K + 2, 1'b1, 8'h55, 1'b1, 1'b0, 0);
    // Back-to-back reads, one idle clock between them.
    run_cycle(KIND_RD, 16'hA001, 8'h01, S + 5, 1, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_cycle(KIND_RD, 16'hA002, 8'h02, S + 7, K + 2, 1'b0, 8'h00, 1'b1, 1'b0, 1);

    // Reset pulse while a claimed read sits in HOLD.
    bus_addr    = 16'h8123;
    bus_din     = 8'h00;
    bus_rd_n    = 1'b0;
    bus_merq_n  = 1'b0;
    bus_sltsl_n = 1'b0;
    busreq      = 1'b1;
    cdout       = 8'hA5;
    repeat (K + S + 5) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    check_val("oe_before_reset", bus_oe, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_state("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    en_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (enable) en_cnt++;
    end
    check_val("no_enable_after_reset", en_cnt, 0);
    pins_idle();
    repeat (K + 4) @(negedge clk);
    exp_addr = '0;
    exp_cdin = '0;
    run_cycle(KIND_RD, 16'h8124, 8'h10, S + 6, K + 2, 1'b1, 8'hC3, 1'b1, 1'b0, 0);

    // Randomised cycles.
    for (int t = 0; t < 40; t++) begin
      int kind, len, gap, sel;
      sel = $urandom_range(0, 9);
      kind = (sel < 5) ? KIND_RD : (sel < 8) ? KIND_WR : (sel == 8) ? KIND_RW : KIND_NOSEL;
      len = $urandom_range(S + 3, S + 10);
      if ($urandom_range(0, 7) == 0) len = $urandom_range(1, S);
      gap = $urandom_range(K + 1, K + 4);
      run_cycle(kind, 16'($urandom), 8'($urandom), len, gap, 1'($urandom),
                8'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
